expr_result_unpacker: RTL and testbench

- Receiver-side counterpart to the regression expression blocks. Those blocks pack 18 result fields (y0..y17) into one 90-bit word.
- This block accepts one packed word per valid/ready transfer and emits the fields one per beat.
- Each emitted field carries its index, width and signedness, and is sign- or zero-extended to 6 bits.
- On the last beat it also presents an XOR checksum of all emitted values.
- Sits between the expression DUT output capture and the regression scoreboard/trace logger.

---
 rtl/expr_result_unpacker_if.sv | 43 ++++
 rtl/expr_result_unpacker.sv | 136 +++++++++++++
 tb/tb_expr_result_unpacker.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/expr_result_unpacker_if.sv
// ---------------------------------------------------------------------------
// expr_result_unpacker_if
//   Handshake bundle between the expression capture side (packed words in)
//   and the scoreboard / trace logger side (one field beat out).
//
//   in_valid / in_ready / in_data   : packed word transfer, field 0 in MSBs
//   out_valid / out_ready           : field beat transfer
//   out_idx, out_width, out_signed  : field descriptor of the current beat
//   out_value                       : field value extended to 6 bits
//   out_last, out_chk               : last-beat flag and XOR of all values
//
//   slave  : unpacker side
//   master : producer / consumer side (bench or surrounding logic)
// ---------------------------------------------------------------------------
interface expr_result_unpacker_if #(
    parameter int FIELDS = 18
);
    localparam int DATA_W = FIELDS * 5;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        out_idx;
    logic [2:0]        out_width;
    logic              out_signed;
    logic [5:0]        out_value;
    logic              out_last;
    logic [5:0]        out_chk;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_idx, out_width, out_signed,
               out_value, out_last, out_chk
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_idx, out_width, out_signed,
               out_value, out_last, out_chk
    );
endinterface

// File: rtl/expr_result_unpacker.sv
// ---------------------------------------------------------------------------
// expr_result_unpacker
//   Takes one packed result word (FIELDS fields, widths 4/5/6 repeating,
//   fields 3..5 of every group of six signed) and emits it one field per
//   beat, each field extended to 6 bits, with a running XOR checksum that is
//   complete on the last beat.  A new word is accepted on the last beat's
//   handshake so consecutive words stream without a bubble.
//
//   Ports
//     clk    : rising-edge clock
//     reset  : asynchronous, active-high; drops any partially emitted word
//     bus    : expr_result_unpacker_if.slave (word in, field beats out)
// ---------------------------------------------------------------------------
module expr_result_unpacker #(
    parameter int FIELDS = 18
) (
    input  logic                          clk,
    input  logic                          reset,
    expr_result_unpacker_if.slave         bus
);
    localparam int         DATA_W   = FIELDS * 5;
    localparam logic [4:0] LAST_IDX = 5'(FIELDS - 1);

    typedef enum logic { IDLE, EMIT } state_t;

    state_t            state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    // Position inside the current group of six fields; drives width/sign.
    logic [2:0]        ph_q, ph_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [5:0]        chk_q, chk_d;

    logic              emit;
    logic              is_last;
    logic              in_ready_w;
    logic [2:0]        cur_width;
    logic              cur_signed;
    logic [5:0]        cur_value;

    function automatic logic [2:0] phase_width(input logic [2:0] ph);
        case (ph)
            3'd0, 3'd3: phase_width = 3'd4;
            3'd1, 3'd4: phase_width = 3'd5;
            default:    phase_width = 3'd6;
        endcase
    endfunction

    // top holds the six MSBs of the shift register; the field sits left-aligned.
    function automatic logic [5:0] extend_field(input logic [5:0] top,
                                                input logic [2:0] width,
                                                input logic       sgn);
        case (width)
            3'd4:    extend_field = sgn ? {{2{top[5]}}, top[5:2]} : {2'b00, top[5:2]};
            3'd5:    extend_field = sgn ? {top[5], top[5:1]}      : {1'b0, top[5:1]};
            default: extend_field = top;
        endcase
    endfunction

    assign emit       = (state_q == EMIT);
    assign is_last    = (idx_q == LAST_IDX);
    assign cur_width  = phase_width(ph_q);
    assign cur_signed = (ph_q >= 3'd3);
    assign cur_value  = extend_field(sr_q[DATA_W-1 -: 6], cur_width, cur_signed);

    // The only combinational input-to-output path: the last beat's handshake
    // frees the shift register for the next word in the same cycle.
    assign in_ready_w = !emit || (is_last && bus.out_ready);

    // Outputs are forced to their idle values outside EMIT so stale shift
    // register contents never leak after a word completes or is aborted.
    assign bus.in_ready   = in_ready_w;
    assign bus.out_valid  = emit;
    assign bus.out_idx    = emit ? idx_q : 5'd0;
    assign bus.out_width  = emit ? cur_width : 3'd4;
    assign bus.out_signed = emit && cur_signed;
    assign bus.out_value  = emit ? cur_value : 6'd0;
    assign bus.out_last   = emit && is_last;
    assign bus.out_chk    = emit ? (chk_q ^ cur_value) : 6'd0;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ph_d    = ph_q;
        sr_d    = sr_q;
        chk_d   = chk_q;

        if (bus.in_valid && in_ready_w) begin
            // Covers both the IDLE load and the no-bubble reload on the last beat.
            state_d = EMIT;
            sr_d    = bus.in_data;
            idx_d   = 5'd0;
            ph_d    = 3'd0;
            chk_d   = 6'd0;
        end else begin
            case (state_q)
                IDLE: ;
                EMIT: begin
                    if (bus.out_ready) begin
                        if (is_last) begin
                            state_d = IDLE;
                        end else begin
                            case (cur_width)
                                3'd4:    sr_d = sr_q << 4;
                                3'd5:    sr_d = sr_q << 5;
                                default: sr_d = sr_q << 6;
                            endcase
                            idx_d = idx_q + 5'd1;
                            ph_d  = (ph_q == 3'd5) ? 3'd0 : ph_q + 3'd1;
                            chk_d = chk_q ^ cur_value;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 5'd0;
            ph_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ph_q    <= ph_d;
        end
    end

    // Datapath registers carry no reset: they are always reloaded before use
    // and are masked from the outputs while IDLE.
    always_ff @(posedge clk) begin
        sr_q  <= sr_d;
        chk_q <= chk_d;
    end
endmodule

// File: tb/tb_expr_result_unpacker.sv
module tb_expr_result_unpacker;
    localparam int FIELDS = 18;
    localparam int DATA_W = FIELDS * 5;

    typedef struct {
        logic [4:0] idx;
        logic [2:0] width;
        logic       sgn;
        logic [5:0] value;
        logic       last;
        logic [5:0] chk;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    expr_result_unpacker_if #(.FIELDS(FIELDS)) bus();

    expr_result_unpacker #(.FIELDS(FIELDS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int    n_cmp = 0;
    int    n_bad = 0;
    beat_t sb[$];
    int    cyc = 0;
    int    tr_cnt = 0;
    int    tr_first = 0;
    int    tr_last = 0;

    logic [5:0]        hv [0:17];
    logic [DATA_W-1:0] w;
    logic [95:0]       rnd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_out_valid"},  64'(bus.out_valid),  64'd0);
        check({tag, "_in_ready"},   64'(bus.in_ready),   64'd1);
        check({tag, "_out_idx"},    64'(bus.out_idx),    64'd0);
        check({tag, "_out_width"},  64'(bus.out_width),  64'd4);
        check({tag, "_out_signed"}, 64'(bus.out_signed), 64'd0);
        check({tag, "_out_value"},  64'(bus.out_value),  64'd0);
        check({tag, "_out_last"},   64'(bus.out_last),   64'd0);
        check({tag, "_out_chk"},    64'(bus.out_chk),    64'd0);
    endtask

    // Expected beats: width and signedness from the field-index rules,
    // values from the caller's hand table, checksum accumulated here.
    task automatic push_vals(input logic [5:0] v [0:17]);
        beat_t      e;
        logic [5:0] c;
        c = 6'd0;
        for (int k = 0; k < FIELDS; k++) begin
            c       = c ^ v[k];
            e.idx   = 5'(k);
            e.width = 3'(4 + k % 3);
            e.sgn   = ((k % 6) >= 3);
            e.value = v[k];
            e.last  = (k == FIELDS - 1);
            e.chk   = c;
            sb.push_back(e);
        end
    endtask

    // Field extraction by absolute bit position, used for random words.
    function automatic logic [5:0] model_val(input logic [DATA_W-1:0] word, input int k);
        int         pos;
        int         wd;
        logic [5:0] raw;
        pos = DATA_W;
        for (int j = 0; j <= k; j++) pos -= 4 + j % 3;
        wd  = 4 + k % 3;
        raw = 6'((word >> pos) & ((DATA_W'(1) << wd) - DATA_W'(1)));
        if ((k % 6) >= 3 && raw[wd-1]) raw = raw | ~6'((1 << wd) - 1);
        return raw;
    endfunction

    task automatic send_word(input logic [DATA_W-1:0] word, input logic [5:0] v [0:17]);
        bit done;
        done = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = word;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                push_vals(v);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready never 1, expected handshake");
        end
    endtask

    task automatic wait_idx(input int k);
        bit hit;
        hit = 0;
        for (int t = 0; t < 100 && !hit; t++) begin
            if (bus.out_valid && bus.out_idx == 5'(k)) hit = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("wait_idx_reached", 64'(hit), 64'd1);
    endtask

    task automatic drain();
        bit empty;
        empty = 0;
        for (int t = 0; t < 200 && !empty; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.out_valid) empty = 1;
        end
        check("drain_queue_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: a beat transfers at the next rising edge when valid and ready
    // are both high at the falling edge (inputs only change just after rising).
    always @(negedge clk) begin
        beat_t e;
        bit    ok;
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (tr_cnt == 0) tr_first = cyc;
            tr_last = cyc;
            tr_cnt++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL beat_unexpected: got idx=%0d value=%h, expected no beat",
                         bus.out_idx, bus.out_value);
            end else begin
                e  = sb.pop_front();
                ok = (bus.out_idx == e.idx) && (bus.out_width == e.width) &&
                     (bus.out_signed == e.sgn) && (bus.out_value == e.value) &&
                     (bus.out_last == e.last) && (!e.last || bus.out_chk == e.chk);
                if (!ok) begin
                    n_bad++;
                    $display("FAIL beat: got idx=%0d w=%0d s=%0d v=%h last=%0d chk=%h, expected idx=%0d w=%0d s=%0d v=%h last=%0d chk=%h",
                             bus.out_idx, bus.out_width, bus.out_signed, bus.out_value, bus.out_last, bus.out_chk,
                             e.idx, e.width, e.sgn, e.value, e.last, e.chk);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #1;

        // Only field 0 = F: one non-zero beat, checksum 0F.
        hv = '{default: 6'h00};
        hv[0] = 6'h0F;
        w = DATA_W'(4'hF) << 86;
        send_word(w, hv);
        bus.in_valid = 1'b0;
        drain();

        // Field 3 = 4'b1000 (signed), field 4 = 5'b10000 (signed).
        hv = '{default: 6'h00};
        hv[3] = 6'h38;
        hv[4] = 6'h30;
        w = (DATA_W'(4'h8) << 71) | (DATA_W'(5'h10) << 66);
        send_word(w, hv);
        bus.in_valid = 1'b0;
        drain();

        // Mixed word with backpressure at idx 5 (6-bit signed field = 15).
        hv = '{default: 6'h00};
        hv[2]  = 6'h2A;
        hv[5]  = 6'h15;
        hv[6]  = 6'h09;
        hv[15] = 6'h07;
        hv[16] = 6'h0F;
        hv[17] = 6'h21;
        w = (DATA_W'(6'h2A) << 75) | (DATA_W'(6'h15) << 60) | (DATA_W'(4'h9) << 56) |
            (DATA_W'(4'h7) << 11) | (DATA_W'(5'h0F) << 6) | DATA_W'(6'h21);
        send_word(w, hv);
        bus.in_valid = 1'b0;
        wait_idx(5);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_idx",       64'(bus.out_idx),   64'd5);
            check("bp_value",     64'(bus.out_value), 64'h15);
            check("bp_width",     64'(bus.out_width), 64'd6);
            check("bp_in_ready",  64'(bus.in_ready),  64'd0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        drain();

        // Back-to-back: all-ones word then the mixed word, 36 beats in 36 cycles.
        tr_cnt = 0;
        hv = '{default: 6'h00};
        for (int k = 0; k < FIELDS; k++) begin
            case (k % 6)
                0:       hv[k] = 6'h0F;
                1:       hv[k] = 6'h1F;
                default: hv[k] = 6'h3F;
            endcase
        end
        send_word({DATA_W{1'b1}}, hv);
        hv = '{default: 6'h00};
        hv[2]  = 6'h2A;
        hv[5]  = 6'h15;
        hv[6]  = 6'h09;
        hv[15] = 6'h07;
        hv[16] = 6'h0F;
        hv[17] = 6'h21;
        send_word(w, hv);
        bus.in_valid = 1'b0;
        drain();
        check("b2b_beats", 64'(tr_cnt), 64'd36);
        check("b2b_span",  64'(tr_last - tr_first + 1), 64'd36);

        // Random word aborted by reset at idx 9.
        rnd = {$urandom(), $urandom(), $urandom()};
        w   = rnd[DATA_W-1:0];
        for (int k = 0; k < FIELDS; k++) hv[k] = model_val(w, k);
        send_word(w, hv);
        bus.in_valid = 1'b0;
        wait_idx(9);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle("after_abort");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_beat", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        hv = '{default: 6'h00};
        hv[0] = 6'h0F;
        w = DATA_W'(4'hF) << 86;
        send_word(w, hv);
        bus.in_valid = 1'b0;
        drain();

        // Two random words streamed back-to-back, checked against the field model.
        for (int r = 0; r < 2; r++) begin
            rnd = {$urandom(), $urandom(), $urandom()};
            w   = rnd[DATA_W-1:0];
            for (int k = 0; k < FIELDS; k++) hv[k] = model_val(w, k);
            send_word(w, hv);
        end
        bus.in_valid = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
